key_event_decoder: RTL and testbench
====================================

# key_event_decoder

Parametrised successor to the keyboard key decoder. It sits between the PS/2 keyboard receiver (`key_down` / `last_change` / `key_valid`) and the game/record logic. It keeps the level-style `pressed_key` and `direction` vectors. It also adds a press/release event FIFO with a ready/valid handshake, auto-repeat pulses for the direction keys, an edge pulse for select, and an overflow flag.

## Interface
- `NUM_KEYS`, 48: note keys decoded, 1..48. Indices ≥ NUM_KEYS are ignored.
- `FIFO_DEPTH`, 8: event FIFO entries, a power of two ≥ 2.
- `REPEAT_DELAY`, 25_000_000: cycles a direction key is held before the first auto-repeat pulse, ≥ 2.
- `REPEAT_RATE`, 5_000_000: cycles between later auto-repeat pulses, ≥ 2.

- `clk`, input, 1: system clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `key_down`, input, 512: per-scancode held vector from the receiver.
- `last_change`, input, 9: scancode of the most recent make/break.
- `key_valid`, input, 1: one-cycle strobe; `key_down` and `last_change` are valid in that cycle.
- `pressed_key`, output, NUM_KEYS: held state of note keys.
- `direction`, output, 4: held state of up/down/left/right (bits 0..3).
- `dir_pulse`, output, 4: one-cycle pulse per direction, on press and on auto-repeat.
- `select_pulse`, output, 1: one-cycle pulse on a space press.
- `ev_data`, output, 7: FIFO head. Bit 6 is press (1) or release (0); bits 5:0 are the key index.
- `ev_valid`, output, 1: FIFO not empty.
- `ev_ready`, input, 1: consumer pops the head when this and `ev_valid` are both high.
- `overflow`, output, 1: sticky; set when an event is dropped.
- `ovf_clr`, input, 1: clears `overflow`.

## Operation
- **Note map:** fixed 48-entry table, 12 per octave, low to 2-high. Indices used in the tests: 0 = L-Do 9'h012, 12 = M-Do 9'h01C, 47 = 2H-Si 9'h055.
- **Direction codes:** 9'h075 (up), 9'h072 (down), 9'h06B (left), 9'h074 (right). Space is 9'h029.
- **Reset:** all outputs are 0, the FIFO is empty, and all repeat counters are 0.
- **Level registers:** on `key_valid`, `pressed_key[i]` ← `key_down[code[i]]`, `direction[j]` ← `key_down[dcode[j]]`, and the space state is captured. Otherwise they hold.
- **Event generation:**
  - On `key_valid`, if `last_change` matches `code[k]` with k < NUM_KEYS, one event {`key_down[last_change]`, k} is written.
  - No match means no write.
  - A repeated make while the key is already held still writes a press event. There is no filtering.
- **FIFO:**
  - Circular buffer with wrapping read/write pointers and a count of width log2(FIFO_DEPTH)+1.
  - Write while full drops the new event and sets `overflow`.
  - Write and pop in the same cycle while full is accepted; the count is unchanged and nothing is dropped.
  - Write and pop in the same cycle while empty: the pop is ignored (`ev_valid` is 0) and the write lands.
- **Overflow flag:**
  - Set dominates clear when both happen in one cycle.
  - `ovf_clr` has no effect on FIFO contents.
- **Select:** `select_pulse` fires when the registered space state rises from 0 to 1.
- **Auto-repeat, per direction j, two states:**
  - **IDLE:** `direction[j]` = 0, counter = 0. On the rising edge of `direction[j]`, pulse and go to HOLD with counter = 1.
  - **HOLD:** counter increments each cycle.
    - At counter = REPEAT_DELAY: pulse, counter ← REPEAT_DELAY − REPEAT_RATE + 1, so later pulses are REPEAT_RATE apart.
    - When `direction[j]` falls: go to IDLE and clear the counter, with no pulse.
  - Counter width is clog2(REPEAT_DELAY+1).

## Timing
- `key_valid` in cycle t gives:
  - `pressed_key`, `direction` and the FIFO write at edge t+1.
  - `ev_valid` = 1 from t+1 if the FIFO was empty.
  - `dir_pulse` / `select_pulse` in cycle t+1, lasting one cycle and registered.
- Pop at edge e: the next head appears on `ev_data` in cycle e+1. `ev_data` is stable while `ev_valid` is high and `ev_ready` is low.
- Auto-repeat pulses fall at t+1, t+1+REPEAT_DELAY−1, then every REPEAT_RATE cycles while held.
- Reset asserted mid-operation clears the FIFO immediately, drops any pending events, and clears pulses asynchronously. Deassertion is synchronised externally.

## Test plan
- **Basic event:** reset, then `key_valid` with `last_change` = 9'h01C and `key_down[9'h01C]` = 1 → next cycle `pressed_key[12]` = 1, `ev_valid` = 1, `ev_data` = 7'h4C. Release (bit = 0) → `ev_data` = 7'h0C, `pressed_key[12]` = 0.
- **NUM_KEYS boundary:** with NUM_KEYS = 24, strobe 9'h055 → no event, `pressed_key` unchanged. Strobe 9'h012 → `ev_data` = 7'h40.
- **Overflow:** with FIFO_DEPTH = 4, `ev_ready` = 0, push 5 events → `ev_valid` = 1, `overflow` = 1, and popping 4 returns the first 4 in order. Push and pop in the same cycle while full → `overflow` stays 0 when starting clear. `ovf_clr` → 0.
- **Auto-repeat:** with REPEAT_DELAY = 10, REPEAT_RATE = 4, hold up (9'h075) for 30 cycles → `dir_pulse[0]` at relative cycles 1, 10, 14, 18, 22, 26, 30. Release → no further pulses.
- **Select:** space press → exactly one `select_pulse`. A second make while held gives no pulse.
- **Async reset:** assert `reset_n` = 0 mid-hold with 3 events queued → outputs are 0 immediately and `ev_valid` = 0 after release of reset.

Source files
------------

// File: rtl/key_event_decoder.sv
// PS/2 key decoder: held note/direction levels, a press/release event FIFO with
// ready/valid pop, direction auto-repeat pulses, a select edge pulse and a sticky overflow flag.
module key_event_decoder #(
    parameter int NUM_KEYS     = 48,
    parameter int FIFO_DEPTH   = 8,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [511:0]        key_down,
    input  logic [8:0]          last_change,
    input  logic                key_valid,
    output logic [NUM_KEYS-1:0] pressed_key,
    output logic [3:0]          direction,
    output logic [3:0]          dir_pulse,
    output logic                select_pulse,
    output logic [6:0]          ev_data,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic                overflow,
    input  logic                ovf_clr
);
    // Handshake: the head is popped on a clock edge where ev_valid && ev_ready;
    // ev_data holds steady while ev_valid is high and ev_ready is low.

    // Four octaves of twelve, low octave first.
    localparam logic [8:0] NOTE_CODES [48] = '{
        9'h012, 9'h01A, 9'h022, 9'h021, 9'h02A, 9'h032, 9'h031, 9'h03A, 9'h041, 9'h049, 9'h04A, 9'h059,
        9'h01C, 9'h01B, 9'h023, 9'h02B, 9'h034, 9'h033, 9'h03B, 9'h042, 9'h04B, 9'h04C, 9'h052, 9'h05A,
        9'h015, 9'h01D, 9'h024, 9'h02D, 9'h02C, 9'h035, 9'h03C, 9'h043, 9'h044, 9'h04D, 9'h054, 9'h05B,
        9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046, 9'h045, 9'h04E, 9'h055
    };
    localparam logic [8:0] DIR_CODES [4] = '{9'h075, 9'h072, 9'h06B, 9'h074};
    localparam logic [8:0] SPACE_CODE = 9'h029;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(REPEAT_DELAY + 1);
    localparam logic [CW-1:0] CNT_DELAY  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] CNT_PRE    = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(REPEAT_DELAY - REPEAT_RATE + 1);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic          hit;
    logic [5:0]    hit_idx;
    logic          push, pop, full, wr_en, drop;
    logic [6:0]    push_data;
    logic [6:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          space_q;
    logic [3:0]    dir_next;
    logic [0:0]    rep_state [4];
    logic [CW-1:0] rep_cnt   [4];

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (last_change == NOTE_CODES[k]) begin
                hit     = 1'b1;
                hit_idx = 6'(k);
            end
        end
    end

    assign push      = key_valid & hit;
    assign push_data = {key_down[last_change], hit_idx};
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign ev_valid  = (count != '0);
    assign pop       = ev_ready & ev_valid;
    // A pop in the same cycle frees the slot, so a write while full still lands.
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign ev_data   = ev_valid ? mem[rd_ptr] : 7'h00;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            dir_next[j] = key_valid ? key_down[DIR_CODES[j]] : direction[j];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pressed_key  <= '0;
            direction    <= '0;
            space_q      <= 1'b0;
            select_pulse <= 1'b0;
        end else begin
            direction    <= dir_next;
            select_pulse <= key_valid & key_down[SPACE_CODE] & ~space_q;
            if (key_valid) begin
                space_q <= key_down[SPACE_CODE];
                for (int i = 0; i < NUM_KEYS; i++) begin
                    pressed_key[i] <= key_down[NOTE_CODES[i]];
                end
            end
        end
    end

    // The pulse is registered alongside the counter so it is high in the cycle count == DELAY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_pulse <= '0;
            for (int j = 0; j < 4; j++) begin
                rep_state[j] <= ST_IDLE;
                rep_cnt[j]   <= '0;
            end
        end else begin
            for (int j = 0; j < 4; j++) begin
                case (rep_state[j])
                    ST_IDLE: begin
                        if (dir_next[j]) begin
                            rep_state[j] <= ST_HOLD;
                            rep_cnt[j]   <= CW'(1);
                            dir_pulse[j] <= 1'b1;
                        end else begin
                            rep_cnt[j]   <= '0;
                            dir_pulse[j] <= 1'b0;
                        end
                    end
                    default: begin
                        if (!dir_next[j]) begin
                            rep_state[j] <= ST_IDLE;
                            rep_cnt[j]   <= '0;
                            dir_pulse[j] <= 1'b0;
                        end else if (rep_cnt[j] == CNT_DELAY) begin
                            rep_cnt[j]   <= CNT_RELOAD;
                            dir_pulse[j] <= 1'b0;
                        end else begin
                            rep_cnt[j]   <= rep_cnt[j] + CW'(1);
                            dir_pulse[j] <= (rep_cnt[j] == CNT_PRE);
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with a small keymap, shallow FIFO and short repeat timing.
module tb_key_event_decoder;
    localparam int NK = 24;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [511:0]  kd;
    logic [8:0]    last_change;
    logic          key_valid;
    logic [NK-1:0] pressed_key;
    logic [3:0]    direction;
    logic [3:0]    dir_pulse;
    logic          select_pulse;
    logic [6:0]    ev_data;
    logic          ev_valid;
    logic          ev_ready;
    logic          overflow;
    logic          ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;

    key_event_decoder #(
        .NUM_KEYS(NK), .FIFO_DEPTH(4), .REPEAT_DELAY(10), .REPEAT_RATE(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key_down(kd), .last_change(last_change),
        .key_valid(key_valid), .pressed_key(pressed_key), .direction(direction),
        .dir_pulse(dir_pulse), .select_pulse(select_pulse), .ev_data(ev_data),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [8:0] code, input logic down);
        kd[code]    = down;
        last_change = code;
        key_valid   = 1'b1;
        tick();
        key_valid   = 1'b0;
    endtask

    task automatic pop();
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; kd = '0; last_change = '0; key_valid = 1'b0;
        ev_ready = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        chk("rst_pressed", pressed_key, 0);
        chk("rst_dir", direction, 0);
        chk("rst_pulse", dir_pulse, 0);
        chk("rst_select", select_pulse, 0);
        chk("rst_valid", ev_valid, 0);
        chk("rst_data", ev_data, 0);
        chk("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        tick();

        // basic press/release of M-Do
        strobe(9'h01C, 1'b1);
        chk("basic_pressed", pressed_key, 24'h001000);
        chk("basic_valid", ev_valid, 1);
        chk("basic_data", ev_data, 7'h4C);
        strobe(9'h01C, 1'b0);
        chk("basic_rel_pressed", pressed_key, 0);
        chk("basic_head_held", ev_data, 7'h4C);
        pop();
        chk("basic_rel_data", ev_data, 7'h0C);
        pop();
        chk("basic_empty", ev_valid, 0);

        // index beyond NUM_KEYS is ignored
        strobe(9'h055, 1'b1);
        chk("bound_no_event", ev_valid, 0);
        chk("bound_pressed", pressed_key, 0);
        strobe(9'h012, 1'b1);
        chk("bound_low_data", ev_data, 7'h40);
        chk("bound_low_pressed", pressed_key, 24'h000001);
        strobe(9'h012, 1'b0);
        pop();
        chk("bound_rel_data", ev_data, 7'h00);
        chk("bound_rel_valid", ev_valid, 1);
        pop();
        chk("bound_empty", ev_valid, 0);

        // overflow: fifth push dropped, set wins over simultaneous clear
        strobe(9'h01C, 1'b1);
        strobe(9'h01C, 1'b0);
        strobe(9'h012, 1'b1);
        strobe(9'h012, 1'b0);
        chk("ovf_full_clear", overflow, 0);
        ovf_clr = 1'b1;
        strobe(9'h01A, 1'b1);
        ovf_clr = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_valid", ev_valid, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 0);
        chk("ovf_clr_keeps_head", ev_data, 7'h4C);
        chk("ovf_pop0", ev_data, 7'h4C); pop();
        chk("ovf_pop1", ev_data, 7'h0C); pop();
        chk("ovf_pop2", ev_data, 7'h40); pop();
        chk("ovf_pop3", ev_data, 7'h00); pop();
        chk("ovf_drained", ev_valid, 0);

        // push and pop together while full
        strobe(9'h01C, 1'b1);
        strobe(9'h01C, 1'b0);
        strobe(9'h012, 1'b1);
        strobe(9'h012, 1'b0);
        ev_ready = 1'b1;
        strobe(9'h01A, 1'b1);
        ev_ready = 1'b0;
        chk("full_pp_ovf", overflow, 0);
        chk("full_pp_head1", ev_data, 7'h0C); pop();
        chk("full_pp_head2", ev_data, 7'h40); pop();
        chk("full_pp_head3", ev_data, 7'h00); pop();
        chk("full_pp_head4", ev_data, 7'h41); pop();
        chk("full_pp_empty", ev_valid, 0);

        // select edge pulse
        strobe(9'h029, 1'b1);
        chk("sel_pulse", select_pulse, 1);
        chk("sel_no_event", ev_valid, 0);
        tick();
        chk("sel_one_cycle", select_pulse, 0);
        strobe(9'h029, 1'b1);
        chk("sel_repeat_make", select_pulse, 0);
        strobe(9'h029, 1'b0);
        chk("sel_release", select_pulse, 0);

        // auto-repeat on up: pulses at 1, 10, 14, 18, 22, 26, 30
        strobe(9'h075, 1'b1);
        chk("rep_first", dir_pulse, 4'b0001);
        chk("rep_dir", direction, 4'b0001);
        for (int c = 2; c <= 30; c++) begin
            tick();
            chk($sformatf("rep_c%0d", c), dir_pulse,
                (c == 10 || c == 14 || c == 18 || c == 22 || c == 26 || c == 30) ? 4'b0001 : 4'b0000);
        end
        strobe(9'h075, 1'b0);
        chk("rep_rel_dir", direction, 0);
        chk("rep_rel_pulse", dir_pulse, 0);
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("rep_after_rel", dir_pulse, 0);
        end
        strobe(9'h072, 1'b1);
        chk("down_pulse", dir_pulse, 4'b0010);
        chk("down_dir", direction, 4'b0010);
        strobe(9'h072, 1'b0);
        chk("down_rel", direction, 0);

        // async reset mid-hold with queued events
        strobe(9'h01C, 1'b1);
        strobe(9'h01C, 1'b0);
        strobe(9'h012, 1'b1);
        strobe(9'h075, 1'b1);
        chk("ar_pre_pulse", dir_pulse, 4'b0001);
        chk("ar_pre_valid", ev_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("ar_valid", ev_valid, 0);
        chk("ar_data", ev_data, 0);
        chk("ar_pulse", dir_pulse, 0);
        chk("ar_dir", direction, 0);
        chk("ar_pressed", pressed_key, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("ar_post_valid", ev_valid, 0);
        chk("ar_post_pulse", dir_pulse, 0);
        chk("ar_post_ovf", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
